m_parity_rx: RTL

Serial frame receiver that is the checking end of the team's button-parity link. It deserialises one UART-style frame per transfer: start bit, DATA_W data bits LSB-first, one parity bit, one stop bit. It checks parity and stop bit and presents the received word with its AND/OR/XOR reduction flags. It sits between the board's serial input pin and the LED/status logic.

---
 rtl/m_parity_pkg.sv | 28 ++
 rtl/m_parity_rx_sync2.sv | 31 +++
 rtl/m_parity_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/m_parity_pkg.sv
`default_nettype none
// ============================================================================
// Package  : m_parity_pkg
// Brief    : Shared state encoding, default sizes and parity helper for the
//            button-parity serial link (transmit and receive sides).
// Revision : 1.0
// ============================================================================
package m_parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    localparam int DEF_DATA_W       = 5;
    localparam int DEF_CLKS_PER_BIT = 16;

    // Parity bit a transmitter sends for i_data; callers zero-extend narrower words.
    function automatic logic f_parity(input logic [31:0] i_data, input logic i_odd);
        return (^i_data) ^ i_odd;
    endfunction

endpackage : m_parity_pkg
`default_nettype wire

// File: rtl/m_parity_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module   : m_sync2
// Brief    : Two-flop synchroniser for the idle-high serial line.
// Revision : 1.0
// ============================================================================
module m_sync2 (
    input  logic w_clk,
    input  logic w_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Reset to 1 so the line reads as idle and no false start is seen on release.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : m_sync2
`default_nettype wire

// File: rtl/m_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : m_parity_rx
// Brief    : Serial frame receiver: start, DATA_W bits LSB-first, parity, stop;
//            reports the word, its reduction flags and parity/framing errors.
// Revision : 1.0
// ============================================================================
module m_parity_rx
    import m_parity_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rxd,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    output logic              w_perr,
    output logic              w_ferr,
    output logic              w_all,
    output logic              w_any,
    output logic              w_par,
    output logic              w_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] c_half_m1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_full_m1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_last_bit = BW'(DATA_W - 1);

    logic              w_rx_s;
    state_t            r_state;
    state_t            w_next_state;
    logic              w_sample;
    logic              w_done;
    logic [CW-1:0]     r_smp_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_pbit;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;
    logic              r_all;
    logic              r_any;
    logic              r_par;

    m_sync2 u_sync (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .i_d     (w_rxd),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The start bit is checked at its midpoint, every later bit one full bit later.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) w_next_state = ST_START;
            end
            ST_START: begin
                w_sample = (r_smp_cnt == c_half_m1);
                if (w_sample) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                w_sample = (r_smp_cnt == c_full_m1);
                if (w_sample && (r_bit_cnt == c_last_bit)) w_next_state = ST_PARITY;
            end
            ST_PARITY: begin
                w_sample = (r_smp_cnt == c_full_m1);
                if (w_sample) w_next_state = ST_STOP;
            end
            ST_STOP: begin
                w_sample = (r_smp_cnt == c_full_m1);
                if (w_sample) begin
                    w_done       = 1'b1;
                    w_next_state = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rx_s) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_busy = (r_state == ST_START) || (r_state == ST_DATA) ||
                    (r_state == ST_PARITY) || (r_state == ST_STOP);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_smp_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_pbit    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_all     <= 1'b0;
            r_any     <= 1'b0;
            r_par     <= 1'b0;
        end else begin
            r_valid <= w_done;

            if (!w_busy || w_sample) r_smp_cnt <= '0;
            else                     r_smp_cnt <= r_smp_cnt + 1'b1;

            if ((r_state == ST_DATA) && w_sample) begin
                r_shift[r_bit_cnt] <= w_rx_s;
                r_bit_cnt          <= (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + 1'b1;
            end

            if ((r_state == ST_PARITY) && w_sample) r_pbit <= w_rx_s;

            // Results and flags update together so they always describe the same word.
            if (w_done) begin
                r_data <= r_shift;
                r_all  <= &r_shift;
                r_any  <= |r_shift;
                r_par  <= ^r_shift;
                r_perr <= (r_pbit != f_parity(32'(r_shift), PARITY_ODD));
                r_ferr <= ~w_rx_s;
            end
        end
    end

    assign w_data  = r_data;
    assign w_valid = r_valid;
    assign w_perr  = r_perr;
    assign w_ferr  = r_ferr;
    assign w_all   = r_all;
    assign w_any   = r_any;
    assign w_par   = r_par;

endmodule : m_parity_rx
`default_nettype wire
